// File: rtl/video_to_axis_converter.sv
// Native parallel video to AXI4-Stream video bridge.
// Pixel/line counters tag each pixel with SOF, EOL (tlast) and EOF. A
// first-word fall-through FIFO absorbs AXIS backpressure, because the video
// side cannot stall. Dropped pixels and framing faults raise sticky flags.
module video_to_axis_converter #(
  parameter int C_WIDTH     = 8,
  parameter int TUSER_WIDTH = 2,
  parameter int FIFO_DEPTH  = 32,
  parameter int DIM_WIDTH   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_frame_start,
  input  logic                     i_data_valid,
  input  logic [C_WIDTH-1:0]       i_R,
  input  logic [C_WIDTH-1:0]       i_G,
  input  logic [C_WIDTH-1:0]       i_B,
  input  logic [DIM_WIDTH-1:0]     i_hres,
  input  logic [DIM_WIDTH-1:0]     i_vres,
  output logic [3*C_WIDTH-1:0]     o_tdata,
  output logic                     o_tvalid,
  input  logic                     i_tready,
  output logic                     o_tlast,
  output logic [TUSER_WIDTH-1:0]   o_tuser,
  output logic                     o_overflow,
  output logic                     o_frame_err
);

  localparam int DW = 3 * C_WIDTH;
  localparam int EW = DW + 3;                 // {eof, sof, last, data}
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  // ---------------- reset: asynchronous assert, synchronous release
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Two-flop release synchroniser; assertion propagates immediately.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) rst_sync_r <= 2'b00;
    else           rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // ---------------- framing
  state_t               state_r;
  logic [DIM_WIDTH-1:0] h_r, v_r, hres_r, vres_r;
  logic                 seen_pix_r, frame_err_r;

  logic                 dims_ok_s, start_s, restart_s, in_frame_s;
  logic                 push_s, stray_s, sof_s, last_s, eof_s;
  logic [DIM_WIDTH-1:0] h_eff_s, v_eff_s, hres_eff_s, vres_eff_s;

  assign dims_ok_s = (i_hres != {DIM_WIDTH{1'b0}}) && (i_vres != {DIM_WIDTH{1'b0}});

  // Position of the current pixel: a legal frame start forces (0,0) with the
  // freshly presented dimensions so a coincident pixel is the first one.
  always_comb begin
    h_eff_s    = h_r;
    v_eff_s    = v_r;
    hres_eff_s = hres_r;
    vres_eff_s = vres_r;
    start_s    = 1'b0;
    case (state_r)
      WAIT_SOF: in_frame_s = 1'b0;
      ACTIVE:   in_frame_s = 1'b1;
      default:  in_frame_s = 1'b0;
    endcase
    if (i_frame_start && dims_ok_s) begin
      start_s    = 1'b1;
      in_frame_s = 1'b1;
      h_eff_s    = {DIM_WIDTH{1'b0}};
      v_eff_s    = {DIM_WIDTH{1'b0}};
      hres_eff_s = i_hres;
      vres_eff_s = i_vres;
    end else begin
      start_s    = 1'b0;
    end
  end

  assign restart_s = start_s && (state_r == ACTIVE) &&
                     ((h_r != {DIM_WIDTH{1'b0}}) || (v_r != {DIM_WIDTH{1'b0}}));
  assign push_s    = i_data_valid && in_frame_s;
  assign stray_s   = i_data_valid && !in_frame_s;
  assign sof_s     = (h_eff_s == {DIM_WIDTH{1'b0}}) && (v_eff_s == {DIM_WIDTH{1'b0}});
  assign last_s    = (h_eff_s == (hres_eff_s - DIM_WIDTH'(1)));
  assign eof_s     = last_s && (v_eff_s == (vres_eff_s - DIM_WIDTH'(1)));

  // Frame FSM and counters; counters advance even when the FIFO drops a pixel.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= WAIT_SOF;
      h_r         <= {DIM_WIDTH{1'b0}};
      v_r         <= {DIM_WIDTH{1'b0}};
      hres_r      <= {DIM_WIDTH{1'b0}};
      vres_r      <= {DIM_WIDTH{1'b0}};
      seen_pix_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (start_s) begin
        hres_r <= i_hres;
        vres_r <= i_vres;
      end
      if (push_s) begin
        seen_pix_r <= 1'b1;
        if (last_s) begin
          h_r <= {DIM_WIDTH{1'b0}};
          v_r <= v_eff_s + DIM_WIDTH'(1);
        end else begin
          h_r <= h_eff_s + DIM_WIDTH'(1);
          v_r <= v_eff_s;
        end
        state_r <= eof_s ? WAIT_SOF : ACTIVE;
      end else if (start_s) begin
        h_r     <= {DIM_WIDTH{1'b0}};
        v_r     <= {DIM_WIDTH{1'b0}};
        state_r <= ACTIVE;
      end
      if (restart_s || (stray_s && seen_pix_r)) frame_err_r <= 1'b1;
    end
  end

  // ---------------- FIFO with registered head
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic [EW-1:0] wdata_s, head_s, out_r;
  logic          pop_s, wr_en_s, full_s, drop_s, overflow_r, tvalid_r;

  assign full_s       = (count_r == DEPTH_C);
  assign pop_s        = tvalid_r && i_tready;
  assign wr_en_s      = push_s && (!full_s || pop_s);
  assign drop_s       = push_s && full_s && !pop_s;
  assign wdata_s      = {eof_s, sof_s, last_s, i_R, i_G, i_B};
  assign rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
  assign count_nxt_s  = count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
  // The new head is the word being written when it lands in the head slot.
  assign head_s       = (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) ? wdata_s
                                                                : mem_r[rd_ptr_nxt_s];

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= wdata_s;
  end

  // Pointers, occupancy, registered AXIS head and the overflow flag.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      tvalid_r   <= 1'b0;
      out_r      <= {EW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      tvalid_r <= (count_nxt_s != {(AW+1){1'b0}});
      if (count_nxt_s != {(AW+1){1'b0}}) out_r <= head_s;
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  assign o_tvalid    = tvalid_r;
  assign o_tdata     = out_r[DW-1:0];
  assign o_tlast     = out_r[DW];
  assign o_tuser     = TUSER_WIDTH'(out_r[DW+2:DW+1]);
  assign o_overflow  = overflow_r;
  assign o_frame_err = frame_err_r;

endmodule
